// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared EX/MEM stage types: the pipeline payload record and the skid-buffer occupancy encoding.
package ex_mem_skid_reg_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_RADDR_W = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [DEF_XLEN-1:0]    pc;
    logic [DEF_XLEN-1:0]    result;
    logic [DEF_XLEN-1:0]    rs2_data;
    logic [DEF_RADDR_W-1:0] rd;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic [2:0]             funct3;
  } ex_mem_payload_t;

endpackage

// File: rtl/ex_mem_skid_reg_skid.sv
// Generic two-slot skid buffer: registered in_ready, strict FIFO order, flush clears both slots.
module skid_buffer
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occupancy
);

  occ_e         state;
  occ_e         state_nxt;
  logic [W-1:0] skid;
  logic         accept;
  logic         drain;
  logic         load_head_in;
  logic         load_head_skid;
  logic         load_skid;

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  assign occupancy = state;

  // Next occupancy and which slot loads what; flush discards the incoming op.
  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (accept) begin
            state_nxt    = OCC_ONE;
            load_head_in = 1'b1;
          end else begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept && !drain) begin
            state_nxt = OCC_FULL;
            load_skid = 1'b1;
          end else if (accept && drain) begin
            state_nxt    = OCC_ONE;
            load_head_in = 1'b1;
          end else if (drain) begin
            state_nxt = OCC_EMPTY;
          end else begin
            state_nxt = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (drain) begin
            state_nxt      = OCC_ONE;
            load_head_skid = 1'b1;
          end else begin
            state_nxt = OCC_FULL;
          end
        end
        default: state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Valids and ready are decoded from next state so all handshake outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= OCC_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt != OCC_FULL);
      out_valid <= (state_nxt != OCC_EMPTY);
      if (load_head_in) begin
        out_data <= in_data;
      end else if (load_head_skid) begin
        out_data <= skid;
      end
      if (load_skid) begin
        skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register built on a two-slot skid buffer, with EX->EX forwarding tap and stall counter.
module ex_mem_skid_reg
  import ex_mem_skid_reg_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    ex_result,
  input  logic [XLEN-1:0]    ex_rs2_data,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic [2:0]         ex_funct3,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [XLEN-1:0]    mem_pc,
  output logic [XLEN-1:0]    mem_result,
  output logic [XLEN-1:0]    mem_rs2_data,
  output logic [RADDR_W-1:0] mem_rd,
  output logic               mem_reg_write,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic [2:0]         mem_funct3,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cycles
);

  localparam int W = 3 * XLEN + RADDR_W + 6;

  logic [W-1:0] in_data;
  logic [W-1:0] head_data;

  assign in_data = {ex_pc, ex_result, ex_rs2_data, ex_rd,
                    ex_reg_write, ex_mem_read, ex_mem_write, ex_funct3};
  assign {mem_pc, mem_result, mem_rs2_data, mem_rd,
          mem_reg_write, mem_mem_read, mem_mem_write, mem_funct3} = head_data;

  skid_buffer #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (ex_valid),
    .in_ready  (ex_ready),
    .in_data   (in_data),
    .out_valid (mem_valid),
    .out_ready (mem_ready),
    .out_data  (head_data),
    .occupancy (occupancy)
  );

  // x0 is hard-wired zero, so it is never a forwarding source.
  assign fwd_valid = mem_valid & mem_reg_write & (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_result;

  // Saturating count of cycles where MEM holds off a valid head; survives flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (mem_valid && !mem_ready && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
